// File: rtl/sdram_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_arbiter
//   Two-port arbiter in front of a single-request SDRAM controller.
//   Port 0 has priority; port 1 is guaranteed a grant after STARVE_LIMIT
//   consecutive port-0 grants while it was waiting. Read returns are routed
//   back to the requesting port through a 2-entry in-order tag FIFO.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   pN_req/rw/addr/wdata           port N request (req held until pN_ack)
//   pN_ack                         one-cycle pulse when port N is issued
//   pN_rdata/pN_rvalid             port N read return (rdata holds otherwise)
//   sd_addr/sd_rw/sd_wdata         registered request to the controller
//   sd_in_valid                    request strobe (never two cycles in a row)
//   sd_busy                        controller cannot take a request
//   sd_rdata/sd_out_valid          controller read return
//   rd_underflow                   sticky: return arrived with no tag queued
// ---------------------------------------------------------------------------
module sdram_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p0_rw,
    input  logic [22:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_ack,
    output logic [31:0] p0_rdata,
    output logic        p0_rvalid,
    input  logic        p1_req,
    input  logic        p1_rw,
    input  logic [22:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_ack,
    output logic [31:0] p1_rdata,
    output logic        p1_rvalid,
    output logic [22:0] sd_addr,
    output logic        sd_rw,
    output logic [31:0] sd_wdata,
    output logic        sd_in_valid,
    input  logic        sd_busy,
    input  logic [31:0] sd_rdata,
    input  logic        sd_out_valid,
    output logic        rd_underflow
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t          state_q, state_d;
    logic            gnt_q, gnt_d;        // granted port id
    logic            grant_en;
    logic [CW-1:0]   starve_q, starve_d;

    // tag FIFO: one bit per slot holds the port id of an outstanding read
    logic [1:0]      tag_q;
    logic            wr_ptr_q, rd_ptr_q;
    logic [1:0]      cnt_q;
    logic            push, pop, head;

    logic            elig0, elig1;

    // Reads need a free tag slot; writes never return data.
    assign elig0 = p0_req & (p0_rw | (cnt_q < 2'd2));
    assign elig1 = p1_req & (p1_rw | (cnt_q < 2'd2));

    assign sd_in_valid = (state_q == ISSUE);
    assign p0_ack      = (state_q == ISSUE) & ~gnt_q;
    assign p1_ack      = (state_q == ISSUE) &  gnt_q;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= 1'b0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        grant_en = 1'b0;
        starve_d = starve_q;
        case (state_q)
            IDLE: begin
                if (!sd_busy && (elig0 || elig1)) begin
                    grant_en = 1'b1;
                    state_d  = ISSUE;
                    gnt_d    = elig1 & (~elig0 | (starve_q >= CW'(STARVE_LIMIT)));
                end
            end
            ISSUE: state_d = IDLE;  // busy lags in_valid, so never grant here
            default: state_d = IDLE;
        endcase
        // counts port-0 wins over a waiting port 1; any gap in p1 clears it
        if (!elig1)
            starve_d = '0;
        else if (grant_en)
            starve_d = gnt_d ? '0 : starve_q + 1'b1;
    end

    // ---------------- request register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sd_addr  <= '0;
            sd_rw    <= 1'b0;
            sd_wdata <= '0;
        end else if (grant_en) begin
            sd_addr  <= gnt_d ? p1_addr  : p0_addr;
            sd_rw    <= gnt_d ? p1_rw    : p0_rw;
            sd_wdata <= gnt_d ? p1_wdata : p0_wdata;
        end
    end

    // ---------------- tag FIFO ----------------
    assign push = (state_q == ISSUE) & ~sd_rw;
    assign pop  = sd_out_valid & (cnt_q != 2'd0);
    assign head = tag_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                tag_q[wr_ptr_q] <= gnt_q;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop)
                rd_ptr_q <= ~rd_ptr_q;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // ---------------- read return ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            p0_rvalid    <= 1'b0;
            p1_rvalid    <= 1'b0;
            p0_rdata     <= '0;
            p1_rdata     <= '0;
            rd_underflow <= 1'b0;
        end else begin
            p0_rvalid <= pop & ~head;
            p1_rvalid <= pop &  head;
            if (pop && !head) p0_rdata <= sd_rdata;
            if (pop &&  head) p1_rdata <= sd_rdata;
            if (sd_out_valid && cnt_q == 2'd0)
                rd_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sdram_arbiter
//   Directed stimulus with a queue-based reference model compared against
//   the DUT on every falling edge, plus literal expectations per scenario.
// ---------------------------------------------------------------------------
module tb_sdram_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_rw, p1_req, p1_rw;
    logic [22:0] p0_addr, p1_addr;
    logic [31:0] p0_wdata, p1_wdata;
    logic        p0_ack, p1_ack, p0_rvalid, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic [22:0] sd_addr;
    logic        sd_rw, sd_in_valid, sd_busy, sd_out_valid, rd_underflow;
    logic [31:0] sd_wdata, sd_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    sdram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_rw(p0_rw), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_rvalid(p0_rvalid),
        .p1_req(p1_req), .p1_rw(p1_rw), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid),
        .sd_addr(sd_addr), .sd_rw(sd_rw), .sd_wdata(sd_wdata),
        .sd_in_valid(sd_in_valid), .sd_busy(sd_busy), .sd_rdata(sd_rdata),
        .sd_out_valid(sd_out_valid), .rd_underflow(rd_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          tq[$];            // outstanding read port ids, oldest first
    int          starve;
    logic        m_live = 1'b0;
    logic        m_issue, m_port, m_rw, m_rv0, m_rv1, m_uf;
    logic [22:0] m_addr;
    logic [31:0] m_wdata, m_rd0, m_rd1;

    always @(posedge clk) begin : model
        int qs, p;
        bit e0, e1, ch;
        if (rst) begin
            tq.delete();
            starve  <= 0;
            m_live  <= 1'b1;
            m_issue <= 0; m_port <= 0; m_rw <= 0; m_addr <= '0; m_wdata <= '0;
            m_rv0   <= 0; m_rv1  <= 0; m_rd0 <= '0; m_rd1 <= '0; m_uf <= 0;
        end else begin
            qs = tq.size();
            e0 = p0_req && (p0_rw || qs < 2);
            e1 = p1_req && (p1_rw || qs < 2);
            m_rv0 <= 0;
            m_rv1 <= 0;
            if (sd_out_valid) begin
                if (qs > 0) begin
                    p = tq.pop_front();
                    if (p == 0) begin m_rv0 <= 1; m_rd0 <= sd_rdata; end
                    else        begin m_rv1 <= 1; m_rd1 <= sd_rdata; end
                end else
                    m_uf <= 1;
            end
            if (m_issue && !m_rw) tq.push_back(int'(m_port));
            if (!m_issue && !sd_busy && (e0 || e1)) begin
                ch = e1 && (!e0 || starve >= LIMIT);
                m_issue <= 1;
                m_port  <= ch;
                m_addr  <= ch ? p1_addr  : p0_addr;
                m_rw    <= ch ? p1_rw    : p0_rw;
                m_wdata <= ch ? p1_wdata : p0_wdata;
                starve  <= (!e1 || ch) ? 0 : starve + 1;
            end else begin
                m_issue <= 0;
                if (!e1) starve <= 0;
            end
        end
    end

    logic prev_iv = 1'b0;
    always @(negedge clk) begin
        if (m_live) begin
            check("in_valid", sd_in_valid, m_issue);
            check("p0_ack", p0_ack, m_issue & ~m_port);
            check("p1_ack", p1_ack, m_issue & m_port);
            if (m_issue) begin
                check("sd_addr", sd_addr, m_addr);
                check("sd_rw", sd_rw, m_rw);
                check("sd_wdata", sd_wdata, m_wdata);
            end
            check("p0_rvalid", p0_rvalid, m_rv0);
            check("p1_rvalid", p1_rvalid, m_rv1);
            check("p0_rdata", p0_rdata, m_rd0);
            check("p1_rdata", p1_rdata, m_rd1);
            check("rd_underflow", rd_underflow, m_uf);
            check("in_valid_b2b", prev_iv & sd_in_valid, 1'b0);
        end
        prev_iv = sd_in_valid;
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_ack(input int port);
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((port == 0) ? p0_ack : p1_ack) begin ok = 1; break; end
        end
        check(port == 0 ? "ack0_timeout" : "ack1_timeout", ok, 1);
    endtask

    task automatic do_read(input int port, input logic [22:0] a);
        if (port == 0) begin p0_req = 1; p0_rw = 0; p0_addr = a; end
        else           begin p1_req = 1; p1_rw = 0; p1_addr = a; end
        wait_ack(port);
        if (port == 0) p0_req = 0; else p1_req = 0;
    endtask

    int g[$];
    int exp_g[6] = '{0, 0, 0, 0, 1, 0};
    bit seen;

    initial begin
        rst = 1; p0_req = 0; p1_req = 0; p0_rw = 0; p1_rw = 0;
        p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = '0;
        sd_busy = 0; sd_rdata = '0; sd_out_valid = 0;
        repeat (3) @(negedge clk);
        check("rst_in_valid", sd_in_valid, 0);
        check("rst_underflow", rd_underflow, 0);
        check("rst_sd_addr", sd_addr, 0);
        check("rst_p0_rdata", p0_rdata, 0);
        rst = 0;

        // single read on port 1
        p1_req = 1; p1_rw = 0; p1_addr = 23'h000123;
        wait_ack(1);
        check("t1_addr", sd_addr, 32'h123);
        check("t1_rw", sd_rw, 0);
        check("t1_iv", sd_in_valid, 1);
        p1_req = 0;
        @(negedge clk);
        sd_out_valid = 1; sd_rdata = 32'hDEADBEEF;
        @(negedge clk);
        sd_out_valid = 0;
        check("t1_p1_rvalid", p1_rvalid, 1);
        check("t1_p1_rdata", p1_rdata, 32'hDEADBEEF);
        check("t1_p0_rvalid", p0_rvalid, 0);

        // contention with writes: starvation limit gives p1 the 5th grant
        p0_req = 1; p0_rw = 1; p0_addr = 23'h1000; p0_wdata = 32'hAAAA0000;
        p1_req = 1; p1_rw = 1; p1_addr = 23'h2000; p1_wdata = 32'hBBBB0000;
        for (int i = 0; i < 40 && g.size() < 6; i++) begin
            @(negedge clk);
            if (p0_ack) g.push_back(0);
            if (p1_ack) g.push_back(1);
        end
        p0_req = 0; p1_req = 0;
        check("t2_grants", g.size(), 6);
        for (int i = 0; i < 6 && i < g.size(); i++)
            check("t2_order", g[i], exp_g[i]);
        @(negedge clk);

        // in-order tag return
        do_read(0, 23'h10);
        do_read(1, 23'h20);
        @(negedge clk);
        sd_out_valid = 1; sd_rdata = 32'h11111111;
        @(negedge clk);
        check("t3_p0_rvalid", p0_rvalid, 1);
        check("t3_p0_rdata", p0_rdata, 32'h11111111);
        sd_rdata = 32'h22222222;
        @(negedge clk);
        sd_out_valid = 0;
        check("t3_p1_rvalid", p1_rvalid, 1);
        check("t3_p1_rdata", p1_rdata, 32'h22222222);
        check("t3_p0_hold", p0_rdata, 32'h11111111);

        // FIFO full: write passes a blocked read
        do_read(0, 23'h30);
        do_read(1, 23'h31);
        p0_req = 1; p0_rw = 0; p0_addr = 23'h32;
        p1_req = 1; p1_rw = 1; p1_addr = 23'h40; p1_wdata = 32'hCAFEF00D;
        wait_ack(1);
        check("t4_p0_blocked", p0_ack, 0);
        check("t4_wdata", sd_wdata, 32'hCAFEF00D);
        p1_req = 0;
        seen = 0;
        repeat (5) begin @(negedge clk); seen |= p0_ack; end
        check("t4_p0_waits", seen, 0);
        sd_out_valid = 1; sd_rdata = 32'h0000000A;
        @(negedge clk);
        sd_out_valid = 0;
        check("t4_ret0", p0_rdata, 32'h0000000A);
        wait_ack(0);
        check("t4_addr", sd_addr, 32'h32);
        p0_req = 0;
        @(negedge clk);
        sd_out_valid = 1; sd_rdata = 32'h0000000B;
        @(negedge clk);
        check("t4_ret1", p1_rdata, 32'h0000000B);
        sd_rdata = 32'h0000000C;
        @(negedge clk);
        sd_out_valid = 0;
        check("t4_ret2", p0_rdata, 32'h0000000C);

        // busy hold-off
        sd_busy = 1; p0_req = 1; p0_rw = 1; p0_addr = 23'h50;
        seen = 0;
        repeat (6) begin @(negedge clk); seen |= p0_ack | sd_in_valid; end
        check("t5_busy", seen, 0);
        sd_busy = 0;
        wait_ack(0);
        p0_req = 0;

        // underflow on empty FIFO
        @(negedge clk);
        sd_out_valid = 1; sd_rdata = 32'h55555555;
        @(negedge clk);
        sd_out_valid = 0;
        check("t5_uf", rd_underflow, 1);
        check("t5_no_rv", p0_rvalid | p1_rvalid, 0);
        @(negedge clk);

        // reset mid-operation discards the outstanding tag
        do_read(1, 23'h60);
        rst = 1;
        @(negedge clk);
        check("t6_uf_clr", rd_underflow, 0);
        @(negedge clk);
        rst = 0;
        sd_out_valid = 1; sd_rdata = 32'h66666666;
        @(negedge clk);
        sd_out_valid = 0;
        check("t6_no_rv", p1_rvalid, 0);
        check("t6_uf", rd_underflow, 1);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: maximum consecutive port-0 grants while port 1 waits.
REQ-002 SHALL have port clk, input, 1 bit: clock; all logic on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have ports p0_req / p1_req, input, 1 bit each: request pending; held high until the matching ack.
REQ-005 SHALL have ports p0_rw / p1_rw, input, 1 bit each: 1 = write, 0 = read.
REQ-006 SHALL have ports p0_addr / p1_addr, input, 23 bits each: address of a 32-bit word.
REQ-007 SHALL have ports p0_wdata / p1_wdata, input, 32 bits each: write data.
REQ-008 SHALL have ports p0_ack / p1_ack, output, 1 bit each: one-cycle pulse when the request is issued.
REQ-009 SHALL have ports p0_rdata / p1_rdata, output, 32 bits each: read data.
REQ-010 SHALL have ports p0_rvalid / p1_rvalid, output, 1 bit each: one-cycle pulse that qualifies rdata.
REQ-011 SHALL have ports sd_addr (23), sd_rw (1), sd_wdata (32), sd_in_valid (1), all outputs: request to the SDRAM controller.
REQ-012 SHALL have port sd_busy, input, 1 bit: controller cannot accept a request.
REQ-013 SHALL have ports sd_rdata, input, 32 bits, and sd_out_valid, input, 1 bit: controller read return.
REQ-014 SHALL have port rd_underflow, output, 1 bit: sticky error flag.

Function
REQ-015 SHALL implement an FSM with states IDLE and ISSUE.
REQ-016 Port N SHALL be eligible when pN_req=1 and either pN_rw=1, or the tag FIFO holds fewer than 2 entries.
REQ-017 In IDLE with sd_busy=0 and at least one eligible port, the FSM SHALL grant one port, register its addr/rw/wdata onto sd_*, and go to ISSUE.
REQ-018 In IDLE with sd_busy=1 or no eligible port, the FSM SHALL stay in IDLE.
REQ-019 ISSUE SHALL last exactly 1 cycle, with sd_in_valid=1 and the granted pN_ack=1, then return to IDLE.
REQ-020 A new grant SHALL be impossible in the ISSUE cycle, because busy from the controller lags in_valid by one cycle.
REQ-021 Port 0 SHALL win when both ports are eligible, except as in REQ-022.
REQ-022 After STARVE_LIMIT consecutive port-0 grants while port 1 was eligible, the next grant SHALL go to port 1.
REQ-023 The starvation counter SHALL clear on any port-1 grant and on any cycle in which p1 is not eligible.
REQ-024 A read grant SHALL push the port id into a 2-entry in-order tag FIFO in the ISSUE cycle.
REQ-025 sd_out_valid=1 with the FIFO non-empty SHALL pop the head id and, one cycle later, drive pN_rdata=sd_rdata and pN_rvalid=1 for that port only.
REQ-026 A simultaneous push and pop SHALL leave the occupancy unchanged and preserve order.
REQ-027 sd_out_valid=1 with the FIFO empty SHALL drop the data and set rd_underflow=1 until reset.
REQ-028 pN_rdata SHALL hold its last value when pN_rvalid=0.
REQ-029 sd_in_valid SHALL never be high on two consecutive cycles.

Reset
REQ-030 While rst=1, the FSM SHALL be in IDLE, and FIFO occupancy and the starvation counter SHALL be 0.
REQ-031 While rst=1, all ack, rvalid, sd_in_valid and rd_underflow outputs SHALL be 0.
REQ-032 While rst=1, sd_addr, sd_wdata, pN_rdata and sd_rw SHALL be 0.
REQ-033 Reset mid-operation SHALL discard outstanding read tags, and no rvalid SHALL be produced for them.

Verification
REQ-034 Single read: p1 reads 0x000123 with sd_busy=0 -> sd_in_valid and p1_ack pulse together, sd_addr=0x000123, sd_rw=0; sd_out_valid with sd_rdata=0xDEADBEEF -> next cycle p1_rvalid=1, p1_rdata=0xDEADBEEF, p0_rvalid=0.
REQ-035 Contention: p0 and p1 request continuously with STARVE_LIMIT=4 -> grant order is p0,p0,p0,p0,p1,p0,... and no two consecutive sd_in_valid.
REQ-036 Tag ordering: p0 read then p1 read issued, two returns 0x11111111 then 0x22222222 -> p0 gets 0x11111111, p1 gets 0x22222222.
REQ-037 FIFO full: 2 reads outstanding, p0 read pending, p1 write pending -> p1 write issues and p0 waits until the first return.
REQ-038 Busy/error: sd_busy=1 holds off all grants; sd_out_valid with the FIFO empty -> rd_underflow=1 and no rvalid; rst clears rd_underflow.
